// File: rtl/vid_hline_seq_if.sv
// ---------------------------------------------------------------------------
// vid_hline_seq_if
//
// Purpose: CPU register access bundle for the horizontal line sequencer.
//          Uses the same strobe-write / tristate-read style as the other video
//          registers: a one-cycle write strobe with select and data, and a
//          one-cycle read strobe answered one cycle later by readback data
//          plus a drive enable.
//
// Signals:
//   din       CPU -> seq   W   register write data
//   crwr      CPU -> seq   1   register write strobe, one cycle
//   sel       CPU -> seq   3   register select (0=HP 1=HBB 2=HS 3=HSE 4=HBE
//                              5=COUNT read only)
//   rd        CPU -> seq   1   register read strobe, one cycle
//   dout_out  seq -> CPU   W   readback data
//   dout_oe   seq -> CPU   1   readback drive enable, high the cycle after rd
//
// Modports:
//   master  the CPU side (drives strobes, receives readback)
//   slave   the sequencer side
// ---------------------------------------------------------------------------
interface vid_hline_seq_if #(
  parameter int W = 11
);

  logic [W-1:0] din;
  logic         crwr;
  logic [2:0]   sel;
  logic         rd;
  logic [W-1:0] dout_out;
  logic         dout_oe;

  modport master (
    output din,
    output crwr,
    output sel,
    output rd,
    input  dout_out,
    input  dout_oe
  );

  modport slave (
    input  din,
    input  crwr,
    input  sel,
    input  rd,
    output dout_out,
    output dout_oe
  );

endinterface

// File: rtl/vid_hline_seq.sv
// ---------------------------------------------------------------------------
// vid_hline_seq
//
// Purpose: Horizontal line sequencer for the video timing path. Owns the
//          W-bit horizontal pixel counter and a bank of five compare
//          registers (HP, HBB, HS, HSE, HBE). The line is walked through the
//          ACTIVE, FRONT, SYNC and BACK phases by equality compare of the
//          running count against the register belonging to the current
//          phase. Produces registered hblank, hsync and an end-of-line pulse
//          for the vertical sequencer.
//
// Optional feature macro: VID_HALFLINE_EN
//   defined   : 'half' toggles on every counter wrap and 'lineend' only
//               pulses on wraps where 'half' was 1, so HP describes half a
//               line (interlace equalisation).
//   undefined : 'half' is tied low and 'lineend' pulses on every wrap.
//
// Ports:
//   sys_clk   in   1   system clock, all state changes on rising edge
//   reset     in   1   synchronous, active-high reset
//   tick      in   1   pixel enable; counter and FSM advance only when high
//   bus       slave modport of vid_hline_seq_if (din, crwr, sel, rd,
//                  dout_out, dout_oe)
//   count     out  W   current horizontal count
//   hblank    out  1   high outside the active region
//   hsync     out  1   high during sync
//   lineend   out  1   one-cycle pulse (per tick) on counter wrap
//   half      out  1   half-line phase
// ---------------------------------------------------------------------------
module vid_hline_seq #(
  parameter int W = 11
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         tick,
  vid_hline_seq_if.slave bus,
  output logic [W-1:0] count,
  output logic         hblank,
  output logic         hsync,
  output logic         lineend,
  output logic         half
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } lineState_t;

  localparam logic [W-1:0] MaxCount = '1;
  localparam logic [W-1:0] OneCount = W'(1);

  localparam logic [2:0] SelHp    = 3'd0;
  localparam logic [2:0] SelHbb   = 3'd1;
  localparam logic [2:0] SelHs    = 3'd2;
  localparam logic [2:0] SelHse   = 3'd3;
  localparam logic [2:0] SelHbe   = 3'd4;
  localparam logic [2:0] SelCount = 3'd5;

  // compare bank
  logic [W-1:0] hp_q;
  logic [W-1:0] hbb_q;
  logic [W-1:0] hs_q;
  logic [W-1:0] hse_q;
  logic [W-1:0] hbe_q;

  // counter and line phase
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap;
  lineState_t   state_q;
  lineState_t   state_d;

  // registered outputs
  logic         hblank_q;
  logic         hblank_d;
  logic         hsync_q;
  logic         hsync_d;
  logic         lineEnd_q;
  logic         lineEnd_d;
  logic         half_q;
  logic         half_d;

  // read path
  logic [W-1:0] readData;
  logic [W-1:0] dataOut_q;
  logic         dataOe_q;

  // The compare bank loads from the CPU strobe. Selects 5..7 have no
  // backing register, so those writes simply fall through. A value written
  // here is only seen by the compares from the following cycle, since the
  // compares always look at the register outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hp_q  <= MaxCount;
      hbb_q <= MaxCount;
      hs_q  <= MaxCount;
      hse_q <= MaxCount;
      hbe_q <= '0;
    end else if (bus.crwr) begin
      case (bus.sel)
        SelHp:   hp_q  <= bus.din;
        SelHbb:  hbb_q <= bus.din;
        SelHs:   hs_q  <= bus.din;
        SelHse:  hse_q <= bus.din;
        SelHbe:  hbe_q <= bus.din;
        default: ;
      endcase
    end
  end

  // Wrap is an equality test against HP, backed up by the all-ones test so
  // that shrinking HP below the running count lets the counter run out to
  // the top and fold over instead of jumping straight to zero.
  always_comb begin
    wrap    = (count_q == hp_q) || (count_q == MaxCount);
    count_d = wrap ? '0 : (count_q + OneCount);
  end

  // Horizontal pixel counter, advanced only on pixel ticks.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= count_d;
    end
  end

  // Half-line phase and end-of-line qualification. With the half-line
  // feature each HP period is half a line, so only every other wrap marks
  // the real end of line for the vertical sequencer.
`ifdef VID_HALFLINE_EN
  always_comb begin
    half_d    = half_q ^ wrap;
    lineEnd_d = wrap & half_q;
  end
`else
  always_comb begin
    half_d    = 1'b0;
    lineEnd_d = wrap;
  end
`endif

  // Wrap-related outputs are registered on the tick so that lineend lines
  // up with the cycle in which count reads zero, and holds with the count
  // while tick is low.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      lineEnd_q <= 1'b0;
      half_q    <= 1'b0;
    end else if (tick) begin
      lineEnd_q <= lineEnd_d;
      half_q    <= half_d;
    end
  end

  // Line phase state register. Reset parks in BACK so that with HBE=0 the
  // first tick at count 0 enters ACTIVE.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= BACK;
    end else if (tick) begin
      state_q <= state_d;
    end
  end

  // Next-phase logic. Only the compare that belongs to the current phase is
  // examined, so two registers holding the same value give one step per
  // tick rather than skipping a phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE: if (count_q == hbb_q) state_d = FRONT;
      FRONT:  if (count_q == hs_q)  state_d = SYNC;
      SYNC:   if (count_q == hse_q) state_d = BACK;
      BACK:   if (count_q == hbe_q) state_d = ACTIVE;
      default: state_d = BACK;
    endcase
  end

  // Blank and sync are decoded from the next phase so that, once
  // registered, they change in the same cycle as the counter step that
  // caused the transition.
  always_comb begin
    hblank_d = (state_d != ACTIVE);
    hsync_d  = (state_d == SYNC);
  end

  // Registered blank and sync, held while tick is low.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hblank_q <= 1'b1;
      hsync_q  <= 1'b0;
    end else if (tick) begin
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
    end
  end

  // Readback mux. Register outputs are used, so a write landing on the
  // same edge as the read strobe is not yet visible and the old value is
  // returned.
  always_comb begin
    readData = '0;
    case (bus.sel)
      SelHp:    readData = hp_q;
      SelHbb:   readData = hbb_q;
      SelHs:    readData = hs_q;
      SelHse:   readData = hse_q;
      SelHbe:   readData = hbe_q;
      SelCount: readData = count_q;
      default:  readData = '0;
    endcase
  end

  // Read path runs every clock, independent of tick. The drive enable is
  // the read strobe delayed by one cycle; the data holds until the next
  // read. Reset drops any read strobe that is in flight.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      dataOut_q <= '0;
      dataOe_q  <= 1'b0;
    end else begin
      dataOe_q <= bus.rd;
      if (bus.rd) begin
        dataOut_q <= readData;
      end
    end
  end

  assign count        = count_q;
  assign hblank       = hblank_q;
  assign hsync        = hsync_q;
  assign lineend      = lineEnd_q;
  assign half         = half_q;
  assign bus.dout_out = dataOut_q;
  assign bus.dout_oe  = dataOe_q;

endmodule
